// File: rtl/cmd_sequencer.sv
// Byte-stream instruction sequencer: assembles little-endian instruction words,
// decodes them, and issues commands to a datapath with a valid/ready handshake.
module cmd_sequencer #(
    parameter int BYTE_W      = 8,
    parameter int INSTR_BYTES = 2,
    parameter int OPCODE_W    = 3,
    parameter int ADDR_W      = 9,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [OPCODE_W-1:0] cmd_op,
    output logic [2:0]          cmd_flags,
    output logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_done,
    output logic                busy,
    output logic                halted,
    output logic                err_illegal,
    output logic [CNT_W-1:0]    retired
);
    localparam int INSTR_W   = BYTE_W * INSTR_BYTES;
    localparam int EXT_BYTES = (ADDR_W + BYTE_W - 1) / BYTE_W;
    localparam int EXT_W     = EXT_BYTES * BYTE_W;
    localparam int MAX_BYTES = (INSTR_BYTES > EXT_BYTES) ? INSTR_BYTES : EXT_BYTES;
    localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [IDX_W-1:0] INSTR_LAST = IDX_W'(INSTR_BYTES - 1);
    localparam logic [IDX_W-1:0] EXT_LAST   = IDX_W'(EXT_BYTES - 1);

    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_FETCH = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_RUN   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(5);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXT, S_DISPATCH, S_WAIT, S_HALT
    } state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     byte_idx;
    logic [INSTR_W-1:0]   instr, instr_full;
    logic [EXT_W-1:0]     ext_buf, ext_full;
    logic                 byte_take, last_instr, last_ext;
    logic [OPCODE_W-1:0]  dec_op;
    logic [2:0]           dec_flags;
    logic [ADDR_W-1:0]    dec_addr;
    logic                 unused_bits;

    // Handshakes: a transfer happens on any cycle where valid & ready are both
    // high; the offering side holds valid and payload steady until that cycle.
    assign byte_take  = in_valid & in_ready;
    assign last_instr = (state == S_FETCH) && byte_take && (byte_idx == INSTR_LAST);
    assign last_ext   = (state == S_EXT) && byte_take && (byte_idx == EXT_LAST);

    // Decode sees the word including the byte arriving this cycle.
    always_comb begin
        instr_full = instr;
        instr_full[byte_idx*BYTE_W +: BYTE_W] = in_data;
        ext_full = ext_buf;
        ext_full[byte_idx*BYTE_W +: BYTE_W] = in_data;
    end

    assign dec_op      = instr_full[OPCODE_W-1:0];
    assign dec_flags   = instr_full[OPCODE_W+2:OPCODE_W];
    assign dec_addr    = instr_full[INSTR_W-1 -: ADDR_W];
    assign unused_bits = ^{instr_full, ext_full};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cmd_valid  = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (last_instr) begin
                    case (dec_op)
                        OP_STORE:                  state_next = dec_flags[0] ? S_EXT : S_DISPATCH;
                        OP_FETCH, OP_RUN, OP_LOAD: state_next = S_DISPATCH;
                        OP_HALT:                   state_next = S_HALT;
                        default:                   state_next = S_FETCH;
                    endcase
                end
            end
            S_EXT: begin
                in_ready = 1'b1;
                if (last_ext) state_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cmd_done) state_next = S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx    <= '0;
            instr       <= '0;
            ext_buf     <= '0;
            cmd_op      <= '0;
            cmd_flags   <= '0;
            cmd_addr    <= '0;
            err_illegal <= 1'b0;
            retired     <= '0;
        end else begin
            if (byte_take) begin
                byte_idx <= (last_instr || last_ext) ? '0 : byte_idx + 1'b1;
                if (state == S_FETCH) instr   <= instr_full;
                if (state == S_EXT)   ext_buf <= ext_full;
            end
            if (last_instr) begin
                cmd_op    <= dec_op;
                cmd_flags <= dec_flags;
                cmd_addr  <= dec_addr;
                if (dec_op > OP_NOP) err_illegal <= 1'b1;
            end
            if (last_ext) cmd_addr <= ext_full[ADDR_W-1:0];
            if ((last_instr && dec_op == OP_NOP) || (state == S_WAIT && cmd_done))
                retired <= retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: linear scenario steps with hand-computed
// expectations checked by immediate assertions.
module tb_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_flags;
    logic [8:0]  cmd_addr;
    logic        cmd_done = 1'b0;
    logic        busy;
    logic        halted;
    logic        err_illegal;
    logic [15:0] retired;

    int n_vec = 0;
    int n_err = 0;

    cmd_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_flags(cmd_flags), .cmd_addr(cmd_addr),
        .cmd_done(cmd_done), .busy(busy), .halted(halted),
        .err_illegal(err_illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte and waits (bounded) until it is consumed.
    task automatic send_byte(input logic [7:0] b);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            taken = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!taken) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    // Accepts the pending command (with an ignored cmd_done on the acceptance
    // cycle), then pulses cmd_done after gap further cycles.
    task automatic accept_and_done(input int gap, input logic [15:0] ret_before);
        cmd_ready = 1'b1;
        cmd_done  = 1'b1;
        tick();
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        chk("wait_vrb", {29'd0, cmd_valid, in_ready, busy}, 32'b001);
        chk("retired_hold", {16'd0, retired}, {16'd0, ret_before});
        repeat (gap) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("retired_inc", {16'd0, retired}, {16'd0, ret_before + 16'd1});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {cmd_valid, in_ready, busy, halted, err_illegal, retired, cmd_op, cmd_flags, cmd_addr},
            32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk_reset_outputs("reset_vals");
        rst = 1'b0;
        tick();
        chk("idle_no_start", {30'd0, busy, in_ready}, 32'b00);
        start = 1'b1; tick(); start = 1'b0;
        chk("fetch_entry", {30'd0, busy, in_ready}, 32'b11);

        // Back-to-back RUN: 0x800A -> op 2, flags 1, addr 0x100
        send_byte(8'h0A);
        send_byte(8'h80);
        chk("run_valid", {31'd0, cmd_valid}, 32'd1);
        chk("run_op", {29'd0, cmd_op}, 32'd2);
        chk("run_flags", {29'd0, cmd_flags}, 32'd1);
        chk("run_addr", {23'd0, cmd_addr}, 32'h100);
        chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        accept_and_done(2, 16'd0);
        chk("run_next_ready", {31'd0, in_ready}, 32'd1);

        // Extended STORE: 0x0008 then EXT 0x34, 0x01 -> addr 0x134
        send_byte(8'h08);
        send_byte(8'h00);
        chk("ext_state", {29'd0, in_ready, cmd_valid, busy}, 32'b101);
        send_byte(8'h34);
        send_byte(8'h01);
        chk("st_valid", {31'd0, cmd_valid}, 32'd1);
        chk("st_op", {29'd0, cmd_op}, 32'd0);
        chk("st_flag0", {31'd0, cmd_flags[0]}, 32'd1);
        chk("st_addr", {23'd0, cmd_addr}, 32'h134);
        accept_and_done(1, 16'd1);

        // Stall: LOAD 0xC31B -> op 3, flags 3, addr 0x186; gapped in_valid
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 8'h1B;
        chk("stall_ready0", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; in_data = 8'hEE; tick();
        chk("stall_no_cmd", {31'd0, cmd_valid}, 32'd0);
        in_valid = 1'b1; in_data = 8'hC3; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {16'd0, cmd_valid, cmd_op, cmd_flags, cmd_addr},
                {16'd0, 1'b1, 3'd3, 3'd3, 9'h186});
            tick();
        end
        accept_and_done(0, 16'd2);

        // Illegal opcode then NOP
        send_byte(8'h07);
        send_byte(8'h00);
        chk("ill_err", {29'd0, err_illegal, cmd_valid, in_ready}, 32'b101);
        chk("ill_retired", {16'd0, retired}, 32'd3);
        send_byte(8'h05);
        send_byte(8'h00);
        chk("nop_state", {29'd0, err_illegal, cmd_valid, in_ready}, 32'b101);
        chk("nop_retired", {16'd0, retired}, 32'd4);

        // HALT: stays put despite in_valid and start
        send_byte(8'h04);
        send_byte(8'h00);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            cmd_ready = 1'b1;
            chk("halt_hold", {28'd0, halted, busy, in_ready, cmd_valid}, 32'b1000);
            tick();
        end
        start = 1'b0; in_valid = 1'b0; cmd_ready = 1'b0;
        chk("halt_retired", {16'd0, retired}, 32'd4);

        // Reset mid-WAIT after building up err_illegal and retired
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outputs("reset_after_halt");
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'h07); send_byte(8'h00);
        send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h0A); send_byte(8'h80);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        chk("pre_rst_wait", {16'd0, busy, err_illegal, cmd_valid, retired[12:0]}, {16'd0, 3'b110, 13'd1});
        rst = 1'b1; cmd_done = 1'b1; tick(); rst = 1'b0; cmd_done = 1'b0;
        chk_reset_outputs("reset_mid_wait");

        // Reset mid-instruction; next start must begin at byte index 0
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'hFF);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outputs("reset_mid_fetch");
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'h0B);
        send_byte(8'h00);
        chk("resume_cmd", {16'd0, cmd_valid, cmd_op, cmd_flags, cmd_addr},
            {16'd0, 1'b1, 3'd3, 3'd1, 9'h000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BYTE_W, 8, width of the inbound byte stream.
- INSTR_BYTES, 2, bytes per instruction word; INSTR_W = BYTE_W*INSTR_BYTES.
- OPCODE_W, 3, opcode field width.
- ADDR_W, 9, buffer address width; EXT_BYTES = ceil(ADDR_W/BYTE_W).
- CNT_W, 16, retired-instruction counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, leave IDLE.
- in_valid, in, 1, inbound byte valid (rx FIFO non-empty).
- in_data, in, BYTE_W, inbound byte.
- in_ready, out, 1, byte consumed this cycle when in_valid & in_ready.
- cmd_valid, out, 1, command offered to datapath.
- cmd_ready, in, 1, datapath accepts command.
- cmd_op, out, OPCODE_W, decoded opcode.
- cmd_flags, out, 3, instr[OPCODE_W+2:OPCODE_W].
- cmd_addr, out, ADDR_W, operand address.
- cmd_done, in, 1, single-cycle completion pulse from datapath.
- busy, out, 1, high in any state other than IDLE or HALT.
- halted, out, 1, HALT state.
- err_illegal, out, 1, sticky illegal-opcode flag.
- retired, out, CNT_W, count of completed instructions.

Function
REQ-003 States: IDLE, FETCH, EXT, DISPATCH, WAIT, HALT.
REQ-004 IDLE -> FETCH on start; start is ignored in every other state.
REQ-005 In FETCH, in_ready = 1; accepted bytes assemble little-endian: byte k fills instr[k*BYTE_W +: BYTE_W] for k = 0..INSTR_BYTES-1.
REQ-006 Byte index counter: increments per accepted byte and wraps to 0 after INSTR_BYTES-1; no byte is lost or duplicated under in_valid stalls.
REQ-007 Opcodes: 0 STORE, 1 FETCH, 2 RUN, 3 LOAD, 4 HALT, 5 NOP; 6 and above are illegal.
REQ-008 Default address: cmd_addr = instr[INSTR_W-1 -: ADDR_W].
REQ-009 STORE with flags[0] = 1 -> EXT; read EXT_BYTES bytes little-endian into cmd_addr, truncated to ADDR_W; those bytes override the default address.
REQ-010 Decode occurs on the cycle the last byte (instruction or EXT) is accepted; the next state takes effect the following cycle.
REQ-011 Decode results:
- STORE/FETCH/RUN/LOAD -> DISPATCH.
- NOP -> FETCH, with retired incremented and no command issued.
- HALT -> HALT.
- Illegal -> FETCH, with err_illegal set and retired not incremented.
REQ-012 DISPATCH: cmd_valid = 1 with cmd_op/cmd_flags/cmd_addr stable until cmd_valid & cmd_ready; then -> WAIT. cmd_valid never drops before acceptance.
REQ-013 WAIT: cmd_done -> FETCH and retired += 1 (wraps modulo 2^CNT_W). cmd_done is ignored outside WAIT, including the cycle of acceptance.
REQ-014 in_ready = 0 in IDLE, DISPATCH, WAIT and HALT; 1 in FETCH and EXT.
REQ-015 HALT: halted = 1, all handshakes deasserted; HALT is left only by rst.
REQ-016 Minimum latency: last instruction byte accepted in cycle N -> cmd_valid high in cycle N+1.

Reset
REQ-017 rst is sampled every cycle and overrides all activity, including mid-instruction and mid-handshake.
REQ-018 Reset values: state IDLE, byte index 0, instr 0, cmd_valid 0, in_ready 0, cmd_op/cmd_flags/cmd_addr 0, busy 0, halted 0, err_illegal 0, retired 0.

Verification
REQ-019 The bench shall cover these directed scenarios:
- Back-to-back RUN: bytes 0x0A, 0x80 -> cmd_op = 2, cmd_flags = 1, cmd_addr = 0x100 one cycle after the 2nd byte; cmd_done 3 cycles after acceptance -> retired = 1, next byte accepted.
- Extended STORE: 0x08, 0x00, 0x34, 0x01 -> cmd_op = 0, cmd_flags[0] = 1, cmd_addr = 0x134, with 2 EXT bytes consumed.
- Stall: in_valid toggling each cycle during FETCH, and cmd_ready low for 5 cycles -> command bits held constant, no bytes lost or duplicated.
- Illegal opcode then NOP: 0x07, 0x00, 0x05, 0x00 -> err_illegal = 1, retired = 1, cmd_valid never asserted.
- HALT: 0x04, 0x00 -> halted = 1, in_ready = 0 for 20 cycles despite in_valid = 1 and start pulses.
- Reset mid-WAIT: rst for 1 cycle -> all outputs at their REQ-018 values next cycle; a later start resumes FETCH with byte index 0.
